// File: rtl/sd_clk_gen_if.sv
// ---------------------------------------------------------------------------
// sd_clk_gen_if
// Bundles the control and status signals between an SD bus master and its
// SD clock generator. clk and reset stay outside as plain ports.
//
// Signals:
//   div          requested half-period divider (half-period = div+1 clk)
//   div_load     one-cycle pulse, captures div as the pending divider
//   enable       continuous clock request
//   pause        flow-control hold, parks the clock low
//   burst_start  one-cycle pulse, starts a counted burst
//   burst_len    number of rising edges in the burst
//   sdio_clk     registered SD clock to the pad
//   rise_stb     one-cycle strobe, first cycle sdio_clk reads 1
//   fall_stb     one-cycle strobe, first cycle sdio_clk reads 0
//   running      generator is not stopped
//   div_active   divider currently in use
//   burst_busy   burst in progress
//   burst_done   one-cycle pulse when the burst completes
//
// Modports: master drives the requests, slave is the clock generator.
// ---------------------------------------------------------------------------
interface sd_clk_gen_if #(
    parameter int DIV_WIDTH = 8,
    parameter int CNT_WIDTH = 8
);
    logic [DIV_WIDTH-1:0] div;
    logic                 div_load;
    logic                 enable;
    logic                 pause;
    logic                 burst_start;
    logic [CNT_WIDTH-1:0] burst_len;
    logic                 sdio_clk;
    logic                 rise_stb;
    logic                 fall_stb;
    logic                 running;
    logic [DIV_WIDTH-1:0] div_active;
    logic                 burst_busy;
    logic                 burst_done;

    modport master (
        output div, div_load, enable, pause, burst_start, burst_len,
        input  sdio_clk, rise_stb, fall_stb, running, div_active,
               burst_busy, burst_done
    );

    modport slave (
        input  div, div_load, enable, pause, burst_start, burst_len,
        output sdio_clk, rise_stb, fall_stb, running, div_active,
               burst_busy, burst_done
    );
endinterface

// File: rtl/sd_clk_gen.sv
// ---------------------------------------------------------------------------
// sd_clk_gen
// Runtime-programmable SD bus clock generator running from the SDIO base
// clock. Produces a registered SD clock with glitch-free divider switching,
// stop-low gating (enable/pause), a counted burst mode for card init, and
// rise/fall strobes for the command and data engines.
//
// Ports:
//   clk    SDIO base clock
//   reset  synchronous, active-low reset
//   bus    sd_clk_gen_if.slave (requests in, clock and status out)
// ---------------------------------------------------------------------------
module sd_clk_gen #(
    parameter int DIV_WIDTH = 8,
    parameter int RESET_DIV = 62,
    parameter int CNT_WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    sd_clk_gen_if.slave   bus
);
    typedef enum logic [1:0] {STOPPED, RUN_LOW, RUN_HIGH} state_t;

    localparam logic [DIV_WIDTH-1:0] RESET_DIV_V = DIV_WIDTH'(RESET_DIV);

    state_t               state;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] div_active;
    logic [DIV_WIDTH-1:0] pending;
    logic                 pending_valid;
    logic [CNT_WIDTH-1:0] remaining;
    logic                 last_rise;
    logic                 sdio_clk;
    logic                 rise_stb;
    logic                 fall_stb;
    logic                 running;
    logic                 burst_busy;
    logic                 burst_done;

    logic                 run_cond;
    logic                 phase_end;
    logic                 apply_now;

    // A pending burst count keeps the clock alive even without enable;
    // pause always wins.
    assign run_cond  = ~bus.pause & (bus.enable | (remaining != '0));
    assign phase_end = (state != STOPPED) && (cnt == div_active);

    // The divider only changes on a falling edge or while stopped, so a
    // half-phase is always timed by a single divider value.
    assign apply_now = pending_valid &&
                       ((state == STOPPED) || (state == RUN_HIGH && phase_end));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= STOPPED;
            cnt           <= '0;
            div_active    <= RESET_DIV_V;
            pending       <= RESET_DIV_V;
            pending_valid <= 1'b0;
            remaining     <= '0;
            last_rise     <= 1'b0;
            sdio_clk      <= 1'b0;
            rise_stb      <= 1'b0;
            fall_stb      <= 1'b0;
            running       <= 1'b0;
            burst_busy    <= 1'b0;
            burst_done    <= 1'b0;
        end else begin
            rise_stb   <= 1'b0;
            fall_stb   <= 1'b0;
            burst_done <= 1'b0;

            case (state)
                STOPPED: begin
                    sdio_clk <= 1'b0;
                    cnt      <= '0;
                    if (run_cond) begin
                        state   <= RUN_LOW;
                        running <= 1'b1;
                    end
                end
                RUN_LOW: begin
                    if (phase_end) begin
                        cnt <= '0;
                        if (run_cond) begin
                            sdio_clk <= 1'b1;
                            rise_stb <= 1'b1;
                            state    <= RUN_HIGH;
                            // Enable-driven rises leave a zero count alone.
                            if (remaining != '0) begin
                                remaining <= remaining - CNT_WIDTH'(1);
                                if (remaining == CNT_WIDTH'(1))
                                    last_rise <= 1'b1;
                            end
                        end else begin
                            state   <= STOPPED;
                            running <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end
                RUN_HIGH: begin
                    // High phases always run to completion; only reset cuts them.
                    if (phase_end) begin
                        sdio_clk <= 1'b0;
                        fall_stb <= 1'b1;
                        cnt      <= '0;
                        if (last_rise) begin
                            burst_done <= 1'b1;
                            burst_busy <= 1'b0;
                            last_rise  <= 1'b0;
                        end
                        if (run_cond) begin
                            state <= RUN_LOW;
                        end else begin
                            state   <= STOPPED;
                            running <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state    <= STOPPED;
                    running  <= 1'b0;
                    sdio_clk <= 1'b0;
                    cnt      <= '0;
                end
            endcase

            // A load coinciding with an apply parks the new value for the
            // next opportunity while the older pending value goes live.
            if (apply_now)
                div_active <= pending;
            if (bus.div_load) begin
                pending       <= bus.div;
                pending_valid <= 1'b1;
            end else if (apply_now) begin
                pending_valid <= 1'b0;
            end

            // Remaining is always zero when not busy, so this never races
            // with the decrement above. A zero-length burst just reports done.
            if (bus.burst_start && !burst_busy) begin
                remaining <= bus.burst_len;
                if (bus.burst_len == '0)
                    burst_done <= 1'b1;
                else
                    burst_busy <= 1'b1;
            end
        end
    end

    assign bus.sdio_clk   = sdio_clk;
    assign bus.rise_stb   = rise_stb;
    assign bus.fall_stb   = fall_stb;
    assign bus.running    = running;
    assign bus.div_active = div_active;
    assign bus.burst_busy = burst_busy;
    assign bus.burst_done = burst_done;
endmodule

// File: tb/tb_sd_clk_gen.sv
// ---------------------------------------------------------------------------
// tb_sd_clk_gen
// Self-checking bench for sd_clk_gen: a cycle-by-cycle vector table followed
// by hand-written multi-cycle sequences (reset timing, divider switch,
// pause, bursts, busy-ignore, mid-phase reset).
// ---------------------------------------------------------------------------
module tb_sd_clk_gen;
    logic clk;
    logic reset;

    sd_clk_gen_if #(.DIV_WIDTH(8), .CNT_WIDTH(8)) bus ();

    sd_clk_gen #(.DIV_WIDTH(8), .RESET_DIV(62), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 100 MHz style bench clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] div;
        logic       div_load;
        logic       enable;
        logic       pause;
        logic       burst_start;
        logic [7:0] burst_len;
        logic [5:0] exp_flags;
        logic [7:0] exp_div;
    } vec_t;

    vec_t vecs [23];
    int   passed = 0;
    int   total  = 0;

    // Advances one edge and leaves time 1 unit past it for sampling.
    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual === expected)
            passed++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.div         = v.div;
        bus.div_load    = v.div_load;
        bus.enable      = v.enable;
        bus.pause       = v.pause;
        bus.burst_start = v.burst_start;
        bus.burst_len   = v.burst_len;
        stepClk();
    endtask

    function automatic logic [5:0] flags();
        return {bus.sdio_clk, bus.rise_stb, bus.fall_stb, bus.running,
                bus.burst_busy, bus.burst_done};
    endfunction

    // Holds reset low for two edges, then releases it (no edge consumed).
    task automatic doReset();
        reset = 1'b0;
        stepClk();
        stepClk();
        reset = 1'b1;
    endtask

    // Counts edges until the chosen strobe reads 1 (0 rise, 1 fall, 2 done).
    task automatic waitStrobe(input int which, input int limit, output int n);
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            stepClk();
            n++;
            case (which)
                0:       hit = bus.rise_stb;
                1:       hit = bus.fall_stb;
                default: hit = bus.burst_done;
            endcase
        end
    endtask

    initial begin
        int n;
        int m;
        int rises;
        int falls;
        int overlap;

        reset           = 1'b0;
        bus.div         = '0;
        bus.div_load    = 1'b0;
        bus.enable      = 1'b0;
        bus.pause       = 1'b0;
        bus.burst_start = 1'b0;
        bus.burst_len   = '0;

        // flags = {sdio_clk, rise, fall, running, busy, done}
        vecs[0]  = '{8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 6'b000000, 8'd62};
        vecs[1]  = '{8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'b000000, 8'd0};
        vecs[2]  = '{8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 6'b000100, 8'd0};
        vecs[3]  = '{8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 6'b110100, 8'd0};
        vecs[4]  = '{8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 6'b001100, 8'd0};
        vecs[5]  = '{8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'b000000, 8'd0};
        vecs[6]  = '{8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 6'b000010, 8'd0};
        vecs[7]  = '{8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'b000110, 8'd0};
        vecs[8]  = '{8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'b110110, 8'd0};
        vecs[9]  = '{8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'b001110, 8'd0};
        vecs[10] = '{8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'b110110, 8'd0};
        vecs[11] = '{8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'b001001, 8'd0};
        vecs[12] = '{8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'b000000, 8'd0};
        vecs[13] = '{8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 6'b000001, 8'd0};
        vecs[14] = '{8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'b000000, 8'd0};
        vecs[15] = '{8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 6'b000000, 8'd0};
        vecs[16] = '{8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 6'b000100, 8'd0};
        vecs[17] = '{8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 6'b110100, 8'd0};
        vecs[18] = '{8'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 6'b001100, 8'd3};
        vecs[19] = '{8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'b000100, 8'd3};
        vecs[20] = '{8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'b000100, 8'd3};
        vecs[21] = '{8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'b000100, 8'd3};
        vecs[22] = '{8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 6'b000000, 8'd3};

        // Reset state and the cycle-accurate table.
        $display("[TB] reset and vector table");
        doReset();
        checkOutput("reset_flags", 32'(flags()), 32'd0);
        checkOutput("reset_div", 32'(bus.div_active), 32'd62);
        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vecs[i].exp_flags));
            checkOutput($sformatf("vec%0d_div", i), 32'(bus.div_active), 32'(vecs[i].exp_div));
        end

        // Release reset with enable high at the default divider.
        $display("[TB] reset release timing");
        bus.div_load = 1'b0;
        bus.div = 8'd0;
        bus.pause = 1'b0;
        bus.burst_start = 1'b0;
        bus.enable = 1'b1;
        doReset();
        waitStrobe(0, 1000, n);
        checkOutput("first_rise_delay", n, 64);
        checkOutput("first_rise_clk", 32'(bus.sdio_clk), 1);
        stepClk();
        checkOutput("rise_width", 32'(bus.rise_stb), 0);
        waitStrobe(1, 1000, m);
        checkOutput("high_phase", m + 1, 63);
        stepClk();
        checkOutput("fall_width", 32'(bus.fall_stb), 0);
        waitStrobe(0, 1000, n);
        checkOutput("period", n + m + 2, 126);

        // Divider change requested mid high phase.
        $display("[TB] divider switch");
        for (int i = 0; i < 10; i++) stepClk();
        bus.div = 8'd0;
        bus.div_load = 1'b1;
        stepClk();
        bus.div_load = 1'b0;
        checkOutput("div_held", 32'(bus.div_active), 62);
        waitStrobe(1, 1000, m);
        checkOutput("high_before_switch", 11 + m, 63);
        checkOutput("div_at_fall", 32'(bus.div_active), 0);
        stepClk();
        checkOutput("fast_rise", 32'(bus.rise_stb), 1);
        stepClk();
        checkOutput("fast_fall", 32'(bus.fall_stb), 1);

        // Pause during a high phase at div 3.
        $display("[TB] pause");
        bus.div = 8'd3;
        bus.div_load = 1'b1;
        stepClk();
        bus.div_load = 1'b0;
        waitStrobe(0, 1000, n);
        checkOutput("div3_rise_delay", n, 5);
        stepClk();
        stepClk();
        bus.pause = 1'b1;
        waitStrobe(1, 1000, m);
        checkOutput("paused_high", 2 + m, 4);
        checkOutput("paused_running", 32'(bus.running), 0);
        rises = 0;
        for (int i = 0; i < 5; i++) begin
            stepClk();
            rises += int'(bus.rise_stb);
        end
        checkOutput("paused_rises", rises, 0);
        checkOutput("paused_clk", 32'(bus.sdio_clk), 0);
        bus.pause = 1'b0;
        waitStrobe(0, 1000, n);
        checkOutput("resume_rise_delay", n, 5);

        // 74-clock init burst at div 1, then a zero-length burst.
        $display("[TB] init burst");
        bus.enable = 1'b0;
        doReset();
        bus.div = 8'd1;
        bus.div_load = 1'b1;
        stepClk();
        bus.div_load = 1'b0;
        stepClk();
        checkOutput("burst_div", 32'(bus.div_active), 1);
        bus.burst_len = 8'd74;
        bus.burst_start = 1'b1;
        stepClk();
        bus.burst_start = 1'b0;
        checkOutput("burst_busy_set", 32'(bus.burst_busy), 1);
        rises = 0;
        falls = 0;
        overlap = 0;
        for (int i = 0; i < 1000 && !bus.burst_done; i++) begin
            stepClk();
            rises += int'(bus.rise_stb);
            falls += int'(bus.fall_stb);
            overlap += int'(bus.rise_stb & bus.fall_stb);
        end
        checkOutput("burst_done_seen", 32'(bus.burst_done), 1);
        checkOutput("burst_rises", rises, 74);
        checkOutput("burst_falls", falls, 74);
        checkOutput("strobe_overlap", overlap, 0);
        checkOutput("done_on_fall", 32'(bus.fall_stb), 1);
        checkOutput("done_running", 32'(bus.running), 0);
        checkOutput("done_busy", 32'(bus.burst_busy), 0);
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            stepClk();
            rises += int'(bus.rise_stb);
        end
        checkOutput("post_burst_rises", rises, 0);
        bus.burst_len = 8'd0;
        bus.burst_start = 1'b1;
        stepClk();
        bus.burst_start = 1'b0;
        checkOutput("zero_burst_done", 32'(bus.burst_done), 1);
        checkOutput("zero_burst_busy", 32'(bus.burst_busy), 0);
        stepClk();
        checkOutput("zero_burst_after", 32'(flags()), 0);

        // Busy burst ignores a second start; enable keeps the clock going.
        $display("[TB] busy burst and enable overlap");
        bus.burst_len = 8'd10;
        bus.burst_start = 1'b1;
        stepClk();
        bus.burst_start = 1'b0;
        rises = 0;
        for (int i = 1; i < 1000 && !bus.burst_done; i++) begin
            if (i == 6) begin
                bus.burst_len = 8'd5;
                bus.burst_start = 1'b1;
            end
            if (i == 7) bus.burst_start = 1'b0;
            if (i == 12) bus.enable = 1'b1;
            stepClk();
            rises += int'(bus.rise_stb);
        end
        checkOutput("busy_burst_done", 32'(bus.burst_done), 1);
        checkOutput("busy_burst_rises", rises, 10);
        checkOutput("enable_running", 32'(bus.running), 1);
        rises = 0;
        for (int i = 0; i < 8; i++) begin
            stepClk();
            rises += int'(bus.rise_stb);
        end
        checkOutput("enable_rises_after", rises, 2);

        // Reset pulse in the middle of a high phase with a divider pending.
        $display("[TB] mid-phase reset");
        bus.enable = 1'b1;
        doReset();
        waitStrobe(0, 1000, n);
        checkOutput("pre_reset_rise", n, 64);
        for (int i = 0; i < 3; i++) stepClk();
        bus.div = 8'd5;
        bus.div_load = 1'b1;
        stepClk();
        bus.div_load = 1'b0;
        stepClk();
        reset = 1'b0;
        stepClk();
        checkOutput("reset_mid_flags", 32'(flags()), 0);
        checkOutput("reset_mid_div", 32'(bus.div_active), 62);
        reset = 1'b1;
        waitStrobe(0, 1000, n);
        checkOutput("post_reset_rise", n, 64);
        checkOutput("post_reset_div", 32'(bus.div_active), 62);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
